// File: rtl/shift_register.sv
// Serial-in, serial-out / parallel-out shift register of N bits.
// Ports: clk, reset (sync, high), s_in -> s_out (oldest bit), Q_out (all bits, [0] newest).
module shift_register #(
  parameter int             N           = 8,
  parameter logic [N-1:0]   RESET_VALUE = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         s_in,
  output logic         s_out,
  output logic [N-1:0] Q_out
);

  if (N < 1) begin : g_bad_n
    $error("shift_register: N must be >= 1");
  end

  logic [N-1:0] q;

  if (N == 1) begin : g_one
    always_ff @(posedge clk) begin
      if (reset) q <= RESET_VALUE;
      else       q <= s_in;
    end
  end else begin : g_many
    always_ff @(posedge clk) begin
      if (reset) q <= RESET_VALUE;
      else       q <= {q[N-2:0], s_in};
    end
  end

  assign Q_out = q;
  assign s_out = q[N-1];

endmodule

// File: tb/tb_shift_register.sv
// Self-checking bench for shift_register (N=4 default reset, N=1 with reset value 1).
// Reference model: history of bits sampled since the last reset.
module tb_shift_register;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         s_in;
  logic         s_out;
  logic [N-1:0] Q_out;
  logic         s_out1;
  logic [0:0]   Q_out1;

  int errors = 0;
  int checks = 0;

  bit hist[$];

  always #5 clk = ~clk;

  shift_register #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .s_in  (s_in),
    .s_out (s_out),
    .Q_out (Q_out)
  );

  shift_register #(.N(1), .RESET_VALUE(1'b1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .s_in  (s_in),
    .s_out (s_out1),
    .Q_out (Q_out1)
  );

  function automatic logic [N-1:0] model_q();
    logic [N-1:0] q;
    q = '0;
    for (int i = 0; i < hist.size() && i < N; i++) q[i] = hist[i];
    return q;
  endfunction

  function automatic logic model_q1();
    return (hist.size() > 0) ? hist[0] : 1'b1;
  endfunction

  // Drive junk, wait dly, drive the real values, then cross one edge.
  task automatic tick(input logic r, input logic s, input int dly = 0);
    if (dly > 0) begin
      reset = 1'($urandom);
      s_in  = 1'($urandom);
      #(dly);
    end
    reset = r;
    s_in  = s;
    @(posedge clk);
    if (r) hist.delete();
    else begin
      hist.push_front(s);
      if (hist.size() > N) void'(hist.pop_back());
    end
    #1;
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    checks++;
    if (Q_out !== 4'b0000) begin
      errors++;
      $display("FAIL reset_q: got %b want 0000", Q_out);
    end
    checks++;
    if (s_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_sout: got %b want 0", s_out);
    end
    checks++;
    if (Q_out1 !== 1'b1) begin
      errors++;
      $display("FAIL reset_q_n1: got %b want 1", Q_out1);
    end
  endtask

  task automatic test_walk();
    logic [N-1:0] exp [5];
    exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
    tick(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, (i == 0));
      checks++;
      if (Q_out !== exp[i]) begin
        errors++;
        $display("FAIL walk_q[%0d]: got %b want %b", i, Q_out, exp[i]);
      end
      checks++;
      if (s_out !== (exp[i] == 4'b1000)) begin
        errors++;
        $display("FAIL walk_sout[%0d]: got %b want %b", i, s_out,
                 (exp[i] == 4'b1000));
      end
    end
  endtask

  task automatic test_fill();
    logic [N-1:0] exp [6];
    exp = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1111, 4'b1111};
    tick(1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, 1'b1);
      checks++;
      if (Q_out !== exp[i] || s_out !== (i >= 3)) begin
        errors++;
        $display("FAIL fill[%0d]: got q=%b s=%b want q=%b s=%b",
                 i, Q_out, s_out, exp[i], (i >= 3));
      end
    end
  endtask

  task automatic test_pattern();
    logic pat [4];
    pat = '{1'b1, 1'b0, 1'b1, 1'b1};
    tick(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) tick(1'b0, pat[i]);
    checks++;
    if (Q_out !== 4'b1011 || s_out !== 1'b1) begin
      errors++;
      $display("FAIL pattern_q: got q=%b s=%b want q=1011 s=1", Q_out, s_out);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (s_out !== pat[i]) begin
        errors++;
        $display("FAIL pattern_sout[%0d]: got %b want %b", i, s_out, pat[i]);
      end
      tick(1'b0, 1'b0);
    end
    checks++;
    if (Q_out !== 4'b0000) begin
      errors++;
      $display("FAIL pattern_drain: got %b want 0000", Q_out);
    end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b1);
    checks++;
    if (Q_out !== 4'b1111) begin
      errors++;
      $display("FAIL mid_pre: got %b want 1111", Q_out);
    end
    tick(1'b1, 1'b1);
    checks++;
    if (Q_out !== 4'b0000 || s_out !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got q=%b s=%b want q=0000 s=0", Q_out, s_out);
    end
    tick(1'b0, 1'b1);
    checks++;
    if (Q_out !== 4'b0001) begin
      errors++;
      $display("FAIL mid_resume: got %b want 0001", Q_out);
    end
  endtask

  task automatic test_random();
    logic         r, s;
    logic [N-1:0] eq;
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 9) == 0);
      s = ($urandom_range(0, 9) < 8);
      tick(r, s, int'($urandom_range(0, 7)));
      eq = model_q();
      checks++;
      if (Q_out !== eq || s_out !== eq[N-1]) begin
        errors++;
        $display("FAIL rand[%0d]: got q=%b s=%b want q=%b s=%b",
                 i, Q_out, s_out, eq, eq[N-1]);
      end
      checks++;
      if (Q_out1 !== model_q1() || s_out1 !== model_q1()) begin
        errors++;
        $display("FAIL rand_n1[%0d]: got q=%b s=%b want %b",
                 i, Q_out1, s_out1, model_q1());
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    s_in  = 1'b1;
    test_reset();
    test_walk();
    test_fill();
    test_pattern();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
